// File: rtl/inst_fetch_unit.sv
// Fetch stage: takes a PC, runs one req/ack transaction to instruction
// memory and presents inst/pc/pc+4 to decode over valid/ready.
module inst_fetch_unit #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic [1:0]  fault
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] cnt;
  logic        tmo;

  assign pc_ready = (state == IDLE) && !flush
                 && (!inst_valid || inst_ready);

  assign tmo = (TIMEOUT_CYC != 0) && !imem_ack
            && (cnt == TIMEOUT_CYC - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= '0;
      cnt        <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_pc4   <= '0;
      fault      <= 2'b00;
    end else begin
      // Loads below override this clear when a new result lands.
      if (flush || inst_ready)
        inst_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pc_valid && pc_ready) begin
            if (pc_in[1:0] == 2'b00) begin
              imem_req  <= 1'b1;
              imem_addr <= pc_in;
              pc_q      <= pc_in;
              cnt       <= '0;
              state     <= BUSY;
            end else begin
              inst_valid <= 1'b1;
              inst       <= NOP_WORD;
              inst_pc    <= pc_in;
              inst_pc4   <= pc_in + 32'd4;
              fault      <= 2'b01;
            end
          end
        end
        BUSY: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
            if (!flush) begin
              inst_valid <= 1'b1;
              inst       <= imem_rdata;
              inst_pc    <= pc_q;
              inst_pc4   <= pc_q + 32'd4;
              fault      <= 2'b00;
            end
          end else if (tmo) begin
            imem_req <= 1'b0;
            state    <= IDLE;
            if (!flush) begin
              inst_valid <= 1'b1;
              inst       <= NOP_WORD;
              inst_pc    <= pc_q;
              inst_pc4   <= pc_q + 32'd4;
              fault      <= 2'b10;
            end
          end else begin
            cnt <= cnt + 32'd1;
            if (flush)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem_ack || tmo) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed fetches, a simple
// variable-latency memory responder and a decoupled output monitor.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic [1:0]  fault;

  inst_fetch_unit #(
    .TIMEOUT_CYC(16),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_valid  (pc_valid),
    .pc_ready  (pc_ready),
    .flush     (flush),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_pc4  (inst_pc4),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [1:0]  f;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   ack_dly = 0;
  int   reqcnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h2009_0006;
      32'h0000_0008: return 32'h012A_4020;
      32'h0000_000C: return 32'h0800_0003;
      32'h0000_0040: return 32'hDEAD_BEEF;
      32'h0000_0100: return 32'h3C01_1001;
      32'h0040_0010: return 32'h8C88_0000;
      32'hFFFF_FFFC: return 32'h0000_0020;
      default:       return 32'h1234_5678;
    endcase
  endfunction

  // Memory: ack in the ack_dly-th cycle of a request (0 = never).
  always @(negedge clk) begin
    if (imem_req && !rst) begin
      reqcnt++;
      if (reqcnt == ack_dly) begin
        imem_ack   = 1'b1;
        imem_rdata = data_of(imem_addr);
      end else begin
        imem_ack = 1'b0;
      end
    end else begin
      reqcnt   = 0;
      imem_ack = 1'b0;
    end
  end

  // Monitor: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got inst=%h pc=%h expected none",
                 inst, inst_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_inst", inst, e.i);
        chk("out_pc", inst_pc, e.pc);
        chk("out_pc4", inst_pc4, e.pc4);
        chk("out_fault", {30'd0, fault}, {30'd0, e.f});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [31:0] i, logic [31:0] pc,
                      logic [31:0] pc4, logic [1:0] f);
    q.push_back('{i: i, pc: pc, pc4: pc4, f: f});
  endtask

  task automatic issue(logic [31:0] a);
    int n;
    n = 0;
    pc_valid = 1'b1;
    pc_in    = a;
    #1;
    while (!pc_ready && n < 100) begin
      tick();
      n++;
    end
    if (!pc_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got pc_ready=0 expected 1");
    end
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("sb_drained", q.size(), 0);
  endtask

  task automatic count_req(string nm, logic [31:0] a, int exp_n);
    int n;
    n = 0;
    while (imem_req && n < 100) begin
      chk({nm, "_addr"}, imem_addr, a);
      n++;
      tick();
    end
    chk({nm, "_req_cycles"}, n, exp_n);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", {31'd0, inst_valid}, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_pc4", inst_pc4, 0);
    chk("rst_fault", {30'd0, fault}, 0);
    rst = 1'b0;
    tick();

    // reset while a request is outstanding
    ack_dly = 0;
    issue(32'h0);
    chk("busy_req", {31'd0, imem_req}, 1);
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 0);
    chk("midrst_addr", imem_addr, 0);
    tick();
    rst = 1'b0;
    tick();

    // minimum latency fetch
    ack_dly = 1;
    push(32'h2008_0005, 32'h0, 32'h4, 2'b00);
    issue(32'h0);
    chk("lat_valid_n1", {31'd0, inst_valid}, 0);
    tick();
    chk("lat_valid_n2", {31'd0, inst_valid}, 1);
    wait_empty();

    // backpressure then a 4-address stream
    inst_ready = 1'b0;
    push(32'h2008_0005, 32'h0, 32'h4, 2'b00);
    issue(32'h0);
    tick();
    pc_valid = 1'b1;
    pc_in    = 32'h4;
    for (int k = 0; k < 3; k++) begin
      chk("bp_pc_ready", {31'd0, pc_ready}, 0);
      chk("bp_valid", {31'd0, inst_valid}, 1);
      chk("bp_inst", inst, 32'h2008_0005);
      chk("bp_pc4", inst_pc4, 32'h4);
      chk("bp_req", {31'd0, imem_req}, 0);
      tick();
    end
    inst_ready = 1'b1;
    push(32'h2009_0006, 32'h4, 32'h8, 2'b00);
    push(32'h012A_4020, 32'h8, 32'hC, 2'b00);
    push(32'h0800_0003, 32'hC, 32'h10, 2'b00);
    issue(32'h4);
    issue(32'h8);
    issue(32'hC);
    wait_empty();

    // slow memory
    ack_dly = 5;
    push(32'h8C88_0000, 32'h0040_0010, 32'h0040_0014, 2'b00);
    issue(32'h0040_0010);
    count_req("slow", 32'h0040_0010, 5);
    wait_empty();

    // timeout
    ack_dly = 0;
    push(32'h0, 32'h200, 32'h204, 2'b10);
    issue(32'h200);
    count_req("tmo", 32'h200, 16);
    wait_empty();

    // flush while busy: acked data must be dropped
    ack_dly = 3;
    issue(32'h40);
    flush    = 1'b1;
    pc_valid = 1'b1;
    pc_in    = 32'h100;
    #1;
    chk("flush_pc_ready", {31'd0, pc_ready}, 0);
    tick();
    flush = 1'b0;
    chk("drain_req", {31'd0, imem_req}, 1);
    chk("drain_pc_ready", {31'd0, pc_ready}, 0);
    tick();
    tick();
    chk("drain_done_req", {31'd0, imem_req}, 0);
    chk("drain_valid", {31'd0, inst_valid}, 0);
    ack_dly = 1;
    push(32'h3C01_1001, 32'h100, 32'h104, 2'b00);
    issue(32'h100);
    wait_empty();

    // misaligned
    push(32'h0, 32'h6, 32'hA, 2'b01);
    issue(32'h6);
    chk("mis_req", {31'd0, imem_req}, 0);
    chk("mis_valid", {31'd0, inst_valid}, 1);
    wait_empty();

    // flush clears a held output
    inst_ready = 1'b0;
    issue(32'h2);
    chk("hold_valid", {31'd0, inst_valid}, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_clr_valid", {31'd0, inst_valid}, 0);
    inst_ready = 1'b1;

    // pc+4 wrap-around
    push(32'h0000_0020, 32'hFFFF_FFFC, 32'h0, 2'b00);
    issue(32'hFFFF_FFFC);
    wait_empty();
    tick();
    tick();
    chk("final_sb_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
